instruction_memory_sync: RTL and testbench
==========================================

// Module: instruction_memory_sync
// PURPOSE
//  Synchronous, parametrised instruction memory with a byte-stream program loader.
//  Software images are streamed in one byte at a time, assembled little-endian into
//  32-bit words, and written sequentially from word 0.
//  The core fetches through a registered read port with 1-cycle latency.
//  Misaligned or out-of-range fetches are flagged and return a NOP.
// PARAMETERS
//  DEPTH_WORDS  256           number of 32-bit words; index width = $clog2(DEPTH_WORDS)
//  ADDR_W       32            fetch byte-address width
//  NOP_INSTR    32'h00000013  word returned on an erroneous fetch
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  fetch_req    in   1       fetch request
//  fetch_addr   in   ADDR_W  fetch byte address
//  fetch_ready  out  1       fetch accepted when fetch_req & fetch_ready
//  fetch_valid  out  1       fetch_instr/fetch_err valid this cycle
//  fetch_instr  out  32      fetched instruction word
//  fetch_err    out  1       misaligned or out-of-range fetch
//  load_start   in   1       begin (or restart) program load at word 0
//  load_valid   in   1       load_byte valid
//  load_byte    in   8       program byte
//  load_last    in   1       qualifies final byte of image (with load_valid)
//  load_ready   out  1       byte accepted when load_valid & load_ready
//  load_done    out  1       one-cycle pulse when load completes
//  load_ovf     out  1       sticky: bytes dropped beyond capacity
//  load_words   out  $clog2(DEPTH_WORDS)+1  words written by the last/current load
// BEHAVIOUR
//  States: S_IDLE (after reset), S_LOAD, S_RUN.
//   - fetch_ready = (state==S_RUN); load_ready = (state==S_LOAD).
//  Reset (async, rst_n=0):
//   - state=S_IDLE; fetch_valid=0, fetch_instr=0, fetch_err=0.
//   - load_done=0, load_ovf=0, load_words=0; byte lane ptr=0.
//   - Memory array is NOT cleared; contents are retained/undefined.
//  Transitions:
//   - load_start in any state -> S_LOAD; word ptr=0, lane=0, load_words=0,
//     load_ovf=0, assembly reg=0.
//   - In S_LOAD, load_start has priority over load_valid; a byte in that cycle is discarded.
//   - S_LOAD & load_valid & load_last -> S_RUN; load_done=1 for exactly the next cycle.
//  Load assembly:
//   - Byte with lane k lands in bits [8k+7:8k].
//   - When lane 3 is accepted, or load_last arrives: write word mem[ptr], ptr++,
//     load_words++, lane=0.
//   - A partial final word is written with unfilled upper bytes = 0.
//   - If ptr==DEPTH_WORDS: no write, ptr and load_words hold, load_ovf<=1
//     (the byte is still accepted).
//  Fetch:
//   - Accepted at edge N -> fetch_valid=1 at N+1, one result per accepted request.
//   - Back-to-back fetches are sustained at 1/cycle.
//   - idx = fetch_addr>>2.
//   - fetch_err=1 if fetch_addr[1:0]!=0 or idx>=DEPTH_WORDS; then fetch_instr=NOP_INSTR.
//   - Otherwise fetch_instr=mem[idx], fetch_err=0.
//   - Without an accepted fetch, fetch_valid=0 and fetch_instr/fetch_err hold their values.
//  Simultaneous events:
//   - A fetch accepted in the same cycle as load_start still completes at N+1 with
//     pre-load contents (read-before-write).
//   - No writes occur in S_RUN, so there are no read/write collisions in S_RUN.
//  Reset mid-load:
//   - Partial assembly word is lost; words already written remain.
//   - state=S_IDLE; a new load_start is required before any fetch is accepted.
// TESTING
//  1. Reset then fetch_req=1 for 3 cycles -> fetch_ready=0, fetch_valid stays 0.
//  2. load_start, 8 bytes 0x13,00,00,00,0x93,0x00,0x10,0x00 (last on 8th)
//     -> load_done pulse, load_words=2; fetch 0x0 -> 0x00000013; fetch 0x4 -> 0x00100093.
//  3. Load 5 bytes AA,BB,CC,DD,EE (last on EE) -> load_words=2;
//     fetch 0x4 -> 0x000000EE, err=0.
//  4. Fetch 0x2 -> err=1, instr=0x00000013;
//     fetch 4*DEPTH_WORDS -> err=1, instr=0x00000013.
//  5. DEPTH_WORDS=4, load 20 bytes -> load_words=4, load_ovf=1; words 0-3 correct.
//  6. load_start after 6 bytes, then assert rst_n=0 mid-load -> IDLE, load_words=0,
//     fetch_ready=0; reload succeeds.

Source files
------------

// File: rtl/instruction_memory_sync.sv
// Instruction memory with a byte-stream program loader
// and a registered, error-checked fetch port.
module instruction_memory_sync #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch_req,
    input  logic [ADDR_W-1:0]            fetch_addr,
    output logic                         fetch_ready,
    output logic                         fetch_valid,
    output logic [31:0]                  fetch_instr,
    output logic                         fetch_err,
    input  logic                         load_start,
    input  logic                         load_valid,
    input  logic [7:0]                   load_byte,
    input  logic                         load_last,
    output logic                         load_ready,
    output logic                         load_done,
    output logic                         load_ovf,
    output logic [$clog2(DEPTH_WORDS):0] load_words
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);
    localparam logic [ADDR_W-3:0] DEPTH_A = (ADDR_W-2)'(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t state_q, state_d;

    logic [1:0]       lane_q, lane_d;
    logic [31:0]      asm_q, asm_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             fvalid_q, fvalid_d;
    logic [31:0]      finstr_q, finstr_d;
    logic             ferr_q, ferr_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [31:0]      mem_wdata;

    logic             byte_acc;
    logic             fetch_acc;
    logic             full;
    logic [31:0]      word_w;
    logic [ADDR_W-3:0] idx_hi;
    logic             f_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_start) begin
            state_d = S_LOAD;
        end else if (state_q == S_LOAD && load_valid && load_last) begin
            state_d = S_RUN;
        end
    end

    always_comb begin
        fetch_ready = (state_q == S_RUN);
        load_ready  = (state_q == S_LOAD);
    end

    // load_start wins over a byte presented in the same cycle
    always_comb begin
        byte_acc  = load_ready && load_valid && !load_start;
        full      = (words_q == DEPTH_C);
        word_w    = asm_q | ({24'b0, load_byte} << {lane_q, 3'b000});
        lane_d    = lane_q;
        asm_d     = asm_q;
        words_d   = words_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = words_q[IDX_W-1:0];
        mem_wdata = word_w;
        if (load_start) begin
            lane_d  = 2'd0;
            asm_d   = 32'd0;
            words_d = '0;
            ovf_d   = 1'b0;
        end else if (byte_acc) begin
            done_d = load_last;
            if (full) begin
                ovf_d = 1'b1;
            end
            if (lane_q == 2'd3 || load_last) begin
                lane_d = 2'd0;
                asm_d  = 32'd0;
                if (!full) begin
                    mem_we  = 1'b1;
                    words_d = words_q + 1'b1;
                end
            end else begin
                lane_d = lane_q + 2'd1;
                asm_d  = word_w;
            end
        end
    end

    always_comb begin
        fetch_acc = fetch_req && fetch_ready;
        idx_hi    = fetch_addr[ADDR_W-1:2];
        f_err     = (|fetch_addr[1:0]) || (idx_hi >= DEPTH_A);
        fvalid_d  = fetch_acc;
        finstr_d  = finstr_q;
        ferr_d    = ferr_q;
        if (fetch_acc) begin
            ferr_d   = f_err;
            finstr_d = f_err ? NOP_INSTR : mem[idx_hi[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q   <= 2'd0;
            asm_q    <= 32'd0;
            words_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            fvalid_q <= 1'b0;
            finstr_q <= 32'd0;
            ferr_q   <= 1'b0;
        end else begin
            lane_q   <= lane_d;
            asm_q    <= asm_d;
            words_q  <= words_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            fvalid_q <= fvalid_d;
            finstr_q <= finstr_d;
            ferr_q   <= ferr_d;
        end
    end

    // Array is deliberately not reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign fetch_valid = fvalid_q;
    assign fetch_instr = finstr_q;
    assign fetch_err   = ferr_q;
    assign load_done   = done_q;
    assign load_ovf    = ovf_q;
    assign load_words  = words_q;

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Scoreboard bench for instruction_memory_sync,
// using a 4-word memory so capacity limits are reachable.
module tb_instruction_memory_sync;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = 32'd0;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_err;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'd0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        load_done;
    logic        load_ovf;
    logic [2:0]  load_words;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] img[$];
    int         checks = 0;
    int         passes = 0;

    instruction_memory_sync #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_W(32),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_err(fetch_err),
        .load_start(load_start),
        .load_valid(load_valid),
        .load_byte(load_byte),
        .load_last(load_last),
        .load_ready(load_ready),
        .load_done(load_done),
        .load_ovf(load_ovf),
        .load_words(load_words)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passes++;
    endtask

    always @(negedge clk) begin
        if (fetch_valid) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_fetch: got valid instr %h expected none",
                         fetch_instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("fetch_instr", fetch_instr, e.instr);
                chk("fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei,
                         input logic ee);
        fetch_req  = 1'b1;
        fetch_addr = a;
        sb.push_back('{instr: ei, err: ee});
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic drain();
        repeat (2) tick();
    endtask

    // Start cycle also presents a byte with last set: it must be ignored
    task automatic load_img(input logic do_last);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_byte  = 8'hFF;
        load_last  = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < img.size(); i++) begin
            load_valid = 1'b1;
            load_byte  = img[i];
            load_last  = do_last && (i == img.size() - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_fetch_instr", fetch_instr, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_load_words", {29'd0, load_words}, 32'd0);
        chk("rst_load_ovf", {31'd0, load_ovf}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // idle: fetches refused
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        end
        fetch_req = 1'b0;
        chk("idle_load_ready", {31'd0, load_ready}, 32'd0);

        // two full words
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_img(1'b1);
        chk("t2_done", {31'd0, load_done}, 32'd1);
        chk("t2_words", {29'd0, load_words}, 32'd2);
        chk("t2_ovf", {31'd0, load_ovf}, 32'd0);
        chk("t2_ready", {31'd0, fetch_ready}, 32'd1);
        fetch(32'h0, 32'h00000013, 1'b0);
        chk("t2_done_pulse", {31'd0, load_done}, 32'd0);
        fetch(32'h4, 32'h00100093, 1'b0);
        drain();

        // abandoned start, then restart while loading; partial last word
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_byte  = 8'h55;
        tick();
        load_byte  = 8'h66;
        tick();
        load_valid = 1'b0;
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load_img(1'b1);
        chk("t3_words", {29'd0, load_words}, 32'd2);
        fetch(32'h0, 32'hDDCCBBAA, 1'b0);
        fetch(32'h4, 32'h000000EE, 1'b0);
        drain();
        chk("t3_hold_instr", fetch_instr, 32'h000000EE);
        chk("t3_hold_valid", {31'd0, fetch_valid}, 32'd0);

        // erroneous fetches
        fetch(32'h2, NOP, 1'b1);
        fetch(32'h4 * DEPTH, NOP, 1'b1);
        fetch(32'h80000000, NOP, 1'b1);
        fetch(32'h4, 32'h000000EE, 1'b0);
        drain();

        // overflow: 20 bytes into 4 words
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(8'h10 + i));
        load_img(1'b1);
        chk("t5_words", {29'd0, load_words}, 32'd4);
        chk("t5_ovf", {31'd0, load_ovf}, 32'd1);
        fetch(32'h0, 32'h13121110, 1'b0);
        fetch(32'h4, 32'h17161514, 1'b0);
        fetch(32'h8, 32'h1B1A1918, 1'b0);
        fetch(32'hC, 32'h1F1E1D1C, 1'b0);
        drain();

        // fetch alongside load_start sees old data; then reset mid-load
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        sb.push_back('{instr: 32'h13121110, err: 1'b0});
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        load_img(1'b0);
        fetch_req = 1'b0;
        chk("t6_words_mid", {29'd0, load_words}, 32'd1);
        chk("t6_ovf_clr", {31'd0, load_ovf}, 32'd0);
        chk("t6_load_ready", {31'd0, load_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_words", {29'd0, load_words}, 32'd0);
        chk("t6_rst_fready", {31'd0, fetch_ready}, 32'd0);
        chk("t6_rst_lready", {31'd0, load_ready}, 32'd0);
        chk("t6_rst_instr", fetch_instr, 32'd0);
        tick();
        rst_n = 1'b1;
        fetch_req = 1'b1;
        repeat (2) tick();
        fetch_req = 1'b0;
        chk("t6_idle_fready", {31'd0, fetch_ready}, 32'd0);
        img = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        load_img(1'b1);
        chk("t6_reload_words", {29'd0, load_words}, 32'd1);
        chk("t6_reload_done", {31'd0, load_done}, 32'd1);
        fetch(32'h0, 32'hD4C3B2A1, 1'b0);
        fetch(32'h4, 32'h17161514, 1'b0);
        drain();

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
